// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// Registers the winner onto the port, returns data with a one-cycle ack.
module arbitro_memoria #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] addr0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             erro,
  output logic             seletor,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             ptr_q;
  logic [WDW-1:0]   wd_q;
  logic             ack0_q;
  logic             ack1_q;
  logic [WIDTH-1:0] rdata_q;
  logic             erro_q;
  logic             sel_q;
  logic             mem_req_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             we_q;

  logic             win_d;
  logic             to_hit;

  // Winner: sole requester, else the one not granted last time.
  always_comb begin
    win_d = req1;
    if (req0 && req1) begin
      win_d = ~ptr_q;
    end
    to_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);
  end

  // Grant / access / acknowledge sequencer with registered port outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      wd_q      <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata_q   <= '0;
      erro_q    <= 1'b0;
      sel_q     <= 1'b0;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          erro_q <= 1'b0;
          if (req0 || req1) begin
            sel_q     <= win_d;
            ptr_q     <= win_d;
            addr_q    <= win_d ? addr1 : addr0;
            wdata_q   <= win_d ? wdata1 : '0;
            we_q      <= win_d & we1;
            mem_req_q <= 1'b1;
            wd_q      <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            rdata_q   <= we_q ? '0 : mem_rdata;
            ack0_q    <= ~sel_q;
            ack1_q    <= sel_q;
            erro_q    <= 1'b0;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end else if (to_hit) begin
            rdata_q   <= '0;
            ack0_q    <= ~sel_q;
            ack1_q    <= sel_q;
            erro_q    <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          erro_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign erro      = erro_q;
  assign seletor   = sel_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: vector table plus corner-case sequences,
// checked through an expected-transaction queue.
module tb_arbitro_memoria;

  localparam int W  = 32;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, we1;
  logic [W-1:0]  addr0, addr1, wdata1;
  logic          ack0, ack1, erro, seletor;
  logic          mem_req, mem_we, mem_ready;
  logic [W-1:0]  rdata, mem_addr, mem_wdata, mem_rdata;

  arbitro_memoria #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .erro(erro),
    .seletor(seletor), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          who;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    int          delay;
    logic [31:0] mrd;
    logic [31:0] rdata;
    bit          erro;
    int          busy;
  } exp_t;

  exp_t sb[$];
  exp_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   acks_seen = 0;
  bit   force_rdy = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within budget", name);
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_erro"}, erro, 0);
    chk({tag, "_seletor"}, seletor, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
  endtask

  // Memory model: ready after the configured number of BUSY cycles.
  int busy_cnt = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req && sb.size() > 0) begin
        busy_cnt++;
        mem_ready = force_rdy || (busy_cnt == sb[0].delay);
        mem_rdata = sb[0].mrd;
      end else begin
        busy_cnt  = 0;
        mem_ready = force_rdy;
        mem_rdata = 32'h0BAD0BAD;
      end
    end
  end

  // Monitor: grant contents, port stability, ack contents and timing.
  initial begin
    int          mbusy;
    bit          prev_req;
    logic [31:0] prev_addr;
    bit          prev_ack;
    exp_t        e;
    mbusy = 0;
    prev_req = 0;
    prev_addr = '0;
    prev_ack = 0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req && !prev_req) begin
        mbusy = 0;
        if (sb.size() == 0) begin
          fail_now("grant_unexpected");
        end else begin
          chk("grant_seletor", seletor, sb[0].who);
          chk("grant_addr", mem_addr, sb[0].addr);
          chk("grant_wdata", mem_wdata, sb[0].wdata);
          chk("grant_we", mem_we, sb[0].we);
        end
      end else if (mem_req && prev_req) begin
        chk("addr_stable", mem_addr, prev_addr);
      end
      if (mem_req) mbusy++;
      if (ack0 || ack1) begin
        acks_seen++;
        chk("ack_exclusive", ack0 & ack1, 0);
        chk("ack_pulse", prev_ack, 0);
        chk("mem_req_in_done", mem_req, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none",
                   ack0, ack1);
        end else begin
          e = sb.pop_front();
          chk("ack_who", ack1, e.who);
          chk("ack_rdata", rdata, e.rdata);
          chk("ack_erro", erro, e.erro);
          chk("ack_busy_cycles", mbusy, e.busy);
        end
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
      prev_ack  = ack0 || ack1;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_access(exp_t v);
    int start;
    start = acks_seen;
    sb.push_back(v);
    if (v.who) begin
      addr1  = v.addr;
      wdata1 = v.wdata;
      we1    = v.we;
      addr0  = ~v.addr;
      req1   = 1'b1;
    end else begin
      addr0  = v.addr;
      addr1  = 32'hFFFF_0000;
      wdata1 = 32'hFFFF_FFFF;
      we1    = 1'b1;
      req0   = 1'b1;
    end
    for (int c = 0; c < 64 && acks_seen == start; c++) step();
    if (acks_seen == start) fail_now("ack_wait");
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    int base;
    reset  = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;
    we1    = 1'b0;
    addr0  = '0;
    addr1  = '0;
    wdata1 = '0;

    tbl[0] = '{0, 32'h00400000, 32'h0, 0, 1,
               32'h8C080004, 32'h8C080004, 0, 1};
    tbl[1] = '{1, 32'h10010000, 32'hDEADBEEF, 1, 3,
               32'h12345678, 32'h0, 0, 3};
    tbl[2] = '{1, 32'h10010004, 32'h0, 0, 2,
               32'hCAFEF00D, 32'hCAFEF00D, 0, 2};
    tbl[3] = '{0, 32'h00400004, 32'h0, 0, 0,
               32'h77777777, 32'h0, 1, 16};
    tbl[4] = '{0, 32'h00400008, 32'h0, 0, 1,
               32'h11111111, 32'h11111111, 0, 1};
    tbl[5] = '{1, 32'h10010008, 32'h0, 0, 16,
               32'hA5A5A5A5, 32'hA5A5A5A5, 0, 16};
    tbl[6] = '{0, 32'h0040000C, 32'h0, 0, 15,
               32'h5A5A5A5A, 32'h5A5A5A5A, 0, 15};
    tbl[7] = '{1, 32'h1001000C, 32'hFEEDFACE, 1, 0,
               32'h33333333, 32'h0, 1, 16};

    repeat (3) step();
    chk_idle_outputs("reset");
    reset = 1'b0;
    step();

    // Both held after reset: grants alternate 0,1,0,1.
    sb.push_back('{0, 32'h00400100, 32'h0, 0, 1,
                   32'h01010101, 32'h01010101, 0, 1});
    sb.push_back('{1, 32'h10010100, 32'h0, 0, 2,
                   32'h02020202, 32'h02020202, 0, 2});
    sb.push_back('{0, 32'h00400100, 32'h0, 0, 1,
                   32'h03030303, 32'h03030303, 0, 1});
    sb.push_back('{1, 32'h10010100, 32'h0, 0, 2,
                   32'h04040404, 32'h04040404, 0, 2});
    base   = acks_seen;
    addr0  = 32'h00400100;
    addr1  = 32'h10010100;
    wdata1 = 32'h0;
    we1    = 1'b0;
    req0   = 1'b1;
    req1   = 1'b1;
    for (int c = 0; c < 200 && acks_seen < base + 4; c++) begin
      step();
      if (acks_seen >= base + 3) req0 = 1'b0;
    end
    if (acks_seen < base + 4) fail_now("rr_wait");
    req0 = 1'b0;
    req1 = 1'b0;
    step();

    for (int i = 0; i < 8; i++) do_access(tbl[i]);

    // Select holds after the last grant (requester 1).
    repeat (3) step();
    chk("seletor_hold", seletor, 1);

    // mem_ready outside BUSY must not produce an access or ack.
    force_rdy = 1'b1;
    repeat (3) step();
    force_rdy = 1'b0;
    chk("stray_ready_req", mem_req, 0);
    chk("stray_ready_ack", ack0 | ack1, 0);

    // Reset while BUSY: access discarded, no ack.
    sb.push_back('{0, 32'h00400200, 32'h0, 0, 0,
                   32'h0, 32'h0, 1, 16});
    addr0 = 32'h00400200;
    req0  = 1'b1;
    for (int c = 0; c < 10 && !mem_req; c++) step();
    if (!mem_req) fail_now("busy_wait");
    repeat (3) step();
    reset = 1'b1;
    req0  = 1'b0;
    sb.delete();
    #1;
    chk_idle_outputs("midreset");
    step();
    reset = 1'b0;
    repeat (25) step();
    chk("midreset_no_req", mem_req, 0);

    do_access(tbl[0]);
    repeat (4) step();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
